// File: rtl/ser_rx_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
// PARITY_CHECK_EN adds the PAR state to the FSM at build time.
package ser_rx_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    PAR  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_counter.sv
// Enabled up-counter with synchronous clear, reset and a terminal-count
// strobe. The count returns to 0 after WIDTH-1, so it never runs past
// the last bit index.
module bit_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  assign tc = en && (count == CNT_W'(WIDTH - 1));

  // Count enabled bits; clear on reset, on request, or after the last bit
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/ser_to_par_rx.sv
// Serial-in, parallel-out receiver, MSB first, with a valid/ack word
// handshake and a sticky overrun flag.
// Optional build macro PARITY_CHECK_EN: one trailing even-parity bit per
// word, checked in a PAR state and reported on parErr.
module ser_to_par_rx
  import ser_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bitValid,
  input  logic             serIn,
  input  logic             dataAck,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic             busy,
`ifdef PARITY_CHECK_EN
  output logic             parErr,
`endif
  output logic             overrun
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shReg;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             sh_clr, sh_shift, load_out;
  logic             set_valid, clr_valid, set_ovr;
`ifdef PARITY_CHECK_EN
  logic             par_sample;
`endif

  bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

`ifdef PARITY_CHECK_EN
  assign busy = (state == RECV) || (state == PAR);
`else
  assign busy = (state == RECV);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath control strobes
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    sh_clr    = 1'b0;
    sh_shift  = 1'b0;
    load_out  = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    set_ovr   = 1'b0;
`ifdef PARITY_CHECK_EN
    par_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          sh_clr    = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (bitValid) begin
          cnt_en   = 1'b1;
          sh_shift = 1'b1;
          if (cnt_tc) begin
            load_out  = 1'b1;
`ifdef PARITY_CHECK_EN
            state_nxt = PAR;
`else
            set_valid = 1'b1;
            state_nxt = DONE;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (bitValid) begin
          par_sample = 1'b1;
          set_valid  = 1'b1;
          state_nxt  = DONE;
        end
      end
`endif
      DONE: begin
        if (dataAck) begin
          clr_valid = 1'b1;
          if (start) begin
            // Ack and start together: straight back to RECV, no bubble
            cnt_clr   = 1'b1;
            sh_clr    = 1'b1;
            state_nxt = RECV;
          end else begin
            state_nxt = IDLE;
          end
        end else if (start) begin
          // New word requested while the old one is unconsumed
          set_ovr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, output word, valid and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      shReg     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sh_clr)        shReg <= '0;
      else if (sh_shift) shReg <= {shReg[WIDTH-2:0], serIn};
      if (load_out)      dataOut <= {shReg[WIDTH-2:0], serIn};
      if (set_valid)     dataValid <= 1'b1;
      else if (clr_valid) dataValid <= 1'b0;
      if (set_ovr)       overrun <= 1'b1;
    end
  end

`ifdef PARITY_CHECK_EN
  // Even parity over the word plus its parity bit; held until the next check
  always_ff @(posedge clk) begin
    if (rst)             parErr <= 1'b0;
    else if (par_sample) parErr <= (^dataOut) ^ serIn;
  end
`endif

endmodule

// File: tb/tb_ser_to_par_rx.sv
// Directed bench for ser_to_par_rx (default WIDTH=16). Inputs change 1ns
// after the rising edge; outputs are checked at that same point.
// Build with PARITY_CHECK_EN to exercise the parity bit and parErr.
module tb_ser_to_par_rx;

  logic        clk = 1'b0;
  logic        rst, start, bitValid, serIn, dataAck;
  logic [15:0] dataOut;
  logic        dataValid, busy, overrun;
`ifdef PARITY_CHECK_EN
  logic        parErr;
`endif

  int checks = 0;
  int errors = 0;

  ser_to_par_rx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bitValid  (bitValid),
    .serIn     (serIn),
    .dataAck   (dataAck),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .busy      (busy),
`ifdef PARITY_CHECK_EN
    .parErr    (parErr),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Streams w MSB first from RECV; gap inserts an idle cycle before each bit.
  // With parity enabled, the parity bit p follows and parErr is checked.
  task automatic send_word(input logic [15:0] w, input bit gap, input logic p, input string tag);
    logic [15:0] word;
    word = w;
    for (int i = 15; i >= 0; i--) begin
      if (gap) begin
        bitValid = 1'b0;
        tick();
        chk({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
      end
      chk({tag, "_no_early_valid"}, {31'd0, dataValid}, 32'd0);
      bitValid = 1'b1;
      serIn    = word[i];
      tick();
    end
    bitValid = 1'b0;
    serIn    = 1'b0;
`ifdef PARITY_CHECK_EN
    chk({tag, "_par_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_par_no_valid"}, {31'd0, dataValid}, 32'd0);
    if (gap) tick();
    bitValid = 1'b1;
    serIn    = p;
    tick();
    bitValid = 1'b0;
    serIn    = 1'b0;
    chk({tag, "_parErr"}, {31'd0, parErr}, {31'd0, (^word) ^ p});
`else
    if (p) ; // parity bit unused in this build
`endif
    chk({tag, "_valid"}, {31'd0, dataValid}, 32'd1);
    chk({tag, "_data"}, {16'd0, dataOut}, {16'd0, word});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bitValid = 1'b0; serIn = 1'b0; dataAck = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_data", {16'd0, dataOut}, 32'd0);
    chk("rst_valid", {31'd0, dataValid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);

    // bitValid in IDLE is ignored
    bitValid = 1'b1; serIn = 1'b1;
    tick();
    bitValid = 1'b0;
    chk("idle_bits_busy", {31'd0, busy}, 32'd0);

    // 1: back-to-back word (A5C3 has eight ones: even parity bit 0)
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    send_word(16'hA5C3, 1'b0, 1'b0, "t1");

    // 3: start without ack in DONE -> overrun, word held
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_ovr", {31'd0, overrun}, 32'd1);
    chk("t3_valid_held", {31'd0, dataValid}, 32'd1);
    chk("t3_data_held", {16'd0, dataOut}, 32'h0000A5C3);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t3_ovr_sticky", {31'd0, overrun}, 32'd1);
    dataAck = 1'b1;
    tick();
    dataAck = 1'b0;
    chk("t3_ack_valid", {31'd0, dataValid}, 32'd0);
    chk("t3_ack_idle", {31'd0, busy}, 32'd0);
    chk("t3_ovr_after_ack", {31'd0, overrun}, 32'd1);
    chk("t3_data_kept", {16'd0, dataOut}, 32'h0000A5C3);

    // 2: same word with a gap before every bit; parity bit 1 -> parErr
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(16'hA5C3, 1'b1, 1'b1, "t2");

    // 4: ack and start together -> RECV immediately, second word 0001
    dataAck = 1'b1; start = 1'b1;
    tick();
    dataAck = 1'b0; start = 1'b0;
    chk("t4_valid_clr", {31'd0, dataValid}, 32'd0);
    chk("t4_no_bubble", {31'd0, busy}, 32'd1);
    send_word(16'h0001, 1'b0, 1'b1, "t4");

    // 5: reset mid-word discards it, then a fresh word
    dataAck = 1'b1;
    tick();
    dataAck = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bitValid = 1'b1; serIn = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bitValid = 1'b0;
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_data", {16'd0, dataOut}, 32'd0);
    chk("t5_rst_valid", {31'd0, dataValid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_ovr", {31'd0, overrun}, 32'd0);
`ifdef PARITY_CHECK_EN
    chk("t5_rst_parErr", {31'd0, parErr}, 32'd0);
`endif
    for (int i = 0; i < 4; i++) tick();
    chk("t5_no_late_valid", {31'd0, dataValid}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    // 1234 has five ones: parity bit 1 gives parErr 0
    send_word(16'h1234, 1'b0, 1'b1, "t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
